// File: rtl/exp_lut_sequencer.sv
// Piecewise-linear e^x sequencer: binary-searches a 32-entry breakpoint LUT
// through an external FP compare core, then issues slope*x+intercept to an FMA core.
module exp_lut_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int W       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_x,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [3*W-1:0]    lut_data,
  output logic              cmp_valid,
  output logic [W-1:0]      cmp_a,
  output logic [W-1:0]      cmp_b,
  input  logic              cmp_done,
  input  logic              cmp_lt,
  output logic              fma_valid,
  output logic [W-1:0]      fma_a,
  output logic [W-1:0]      fma_b,
  output logic [W-1:0]      fma_c,
  input  logic              fma_done,
  input  logic [W-1:0]      fma_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_y,
  output logic [ADDR_W-1:0] out_seg,
  output logic              out_err,
  output logic              busy
);

  localparam int BW = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(1) << (ADDR_W - 1);

  typedef enum logic [2:0] {
    IDLE, RD, CMP, CWAIT, FRD, FMA, FWAIT, OUT
  } state_t;

  state_t            state;
  logic [W-1:0]      x;
  logic [ADDR_W-1:0] seg;
  logic [BW-1:0]     bitn;
  logic [TW-1:0]     tmo;

  logic [ADDR_W-1:0] cand;
  logic [ADDR_W-1:0] nseg;
  logic [ADDR_W-1:0] ncand;
  logic [BW-1:0]     nbit;

  // bp[cand] <= x (compare says !lt) keeps the candidate bit set
  always_comb begin
    cand  = seg | (ADDR_W'(1) << bitn);
    nseg  = cmp_lt ? seg : cand;
    nbit  = bitn - 1'b1;
    ncand = nseg | (ADDR_W'(1) << nbit);
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign cmp_a    = x;
  assign fma_b    = x;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      x         <= '0;
      seg       <= '0;
      bitn      <= '0;
      tmo       <= '0;
      lut_addr  <= '0;
      cmp_valid <= 1'b0;
      cmp_b     <= '0;
      fma_valid <= 1'b0;
      fma_a     <= '0;
      fma_c     <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_seg   <= '0;
      out_err   <= 1'b0;
    end else begin
      cmp_valid <= 1'b0;
      fma_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x        <= in_x;
            seg      <= '0;
            bitn     <= BW'(ADDR_W - 1);
            lut_addr <= TOP;
            state    <= RD;
          end
        end
        RD: state <= CMP;
        CMP: begin
          cmp_b     <= lut_data[3*W-1:2*W];
          cmp_valid <= 1'b1;
          tmo       <= '0;
          state     <= CWAIT;
        end
        CWAIT: begin
          if (cmp_done) begin
            seg <= nseg;
            if (bitn == '0) begin
              lut_addr <= nseg;
              state    <= FRD;
            end else begin
              bitn     <= nbit;
              lut_addr <= ncand;
              state    <= RD;
            end
          end else if (tmo == TMAX) begin
            out_y     <= '0;
            out_seg   <= seg;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        FRD: state <= FMA;
        FMA: begin
          fma_a     <= lut_data[2*W-1:W];
          fma_c     <= lut_data[W-1:0];
          fma_valid <= 1'b1;
          tmo       <= '0;
          state     <= FWAIT;
        end
        FWAIT: begin
          if (fma_done) begin
            out_y     <= fma_res;
            out_seg   <= seg;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else if (tmo == TMAX) begin
            out_y     <= '0;
            out_seg   <= seg;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_lut_sequencer.sv
// Directed bench for exp_lut_sequencer with LUT, compare and FMA models.
// Breakpoints are bp[i] = -8 + 0.25*i; the FMA model returns a + b + c.
module tb_exp_lut_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [4:0]  lut_addr;
  logic [95:0] lut_data = '0;
  logic        cmp_valid;
  logic [31:0] cmp_a, cmp_b;
  logic        cmp_done;
  logic        cmp_lt = 1'b0;
  logic        fma_valid;
  logic [31:0] fma_a, fma_b, fma_c;
  logic        fma_done;
  logic [31:0] fma_res = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_y;
  logic [4:0]  out_seg;
  logic        out_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] bp_t [32];
  logic [31:0] sl_t [32];
  logic [31:0] ic_t [32];

  logic cmp_done_m = 1'b0, cmp_done_f = 1'b0;
  logic fma_done_m = 1'b0, fma_done_f = 1'b0;
  bit   cmp_en = 1'b1;
  bit   rnd = 1'b0;
  int   fma_dly = 1;
  int   cmp_cnt = 0;
  int   fma_cnt = 0;
  logic [4:0]  cand_q [$];
  logic [31:0] fa_s = '0, fb_s = '0, fc_s = '0;

  assign cmp_done = cmp_done_m | cmp_done_f;
  assign fma_done = fma_done_m | fma_done_f;

  always #5 clock = ~clock;

  exp_lut_sequencer dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .lut_addr(lut_addr), .lut_data(lut_data),
    .cmp_valid(cmp_valid), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_done(cmp_done), .cmp_lt(cmp_lt),
    .fma_valid(fma_valid), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_done(fma_done), .fma_res(fma_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_seg(out_seg), .out_err(out_err), .busy(busy)
  );

  function automatic logic [31:0] fp_of_q(int q);
    logic [31:0] m, mant;
    int p, e;
    if (q == 0) return 32'h0;
    m = (q < 0) ? 32'(-q) : 32'(q);
    p = 0;
    for (int b = 0; b < 31; b++) if (m[b]) p = b;
    e = p - 2 + 127;
    mant = (m << (23 - p)) & 32'h007F_FFFF;
    return {(q < 0), 8'(e), mant[22:0]};
  endfunction

  // ordered integer key: key(a) < key(b) iff a < b for non-NaN floats
  function automatic logic [31:0] fkey(logic [31:0] f);
    return f[31] ? ~f : (f | 32'h8000_0000);
  endfunction

  function automatic int gold(logic [31:0] xv);
    int s = 0;
    for (int i = 0; i < 32; i++) if (fkey(bp_t[i]) <= fkey(xv)) s = i;
    return s;
  endfunction

  always @(posedge clock) lut_data <= {bp_t[lut_addr], sl_t[lut_addr], ic_t[lut_addr]};

  always @(posedge clock) begin
    cmp_done_m <= 1'b0;
    if (cmp_cnt > 0) begin
      cmp_cnt <= cmp_cnt - 1;
      if (cmp_cnt == 1) begin
        cmp_done_m <= 1'b1;
        cmp_lt     <= fkey(cmp_a) < fkey(cmp_b);
      end
    end else if (cmp_valid && cmp_en) begin
      cmp_cnt <= rnd ? int'($urandom_range(5, 1)) : 1;
    end
  end

  always @(posedge clock) begin
    fma_done_m <= 1'b0;
    if (fma_cnt > 0) begin
      fma_cnt <= fma_cnt - 1;
      if (fma_cnt == 1) begin
        fma_done_m <= 1'b1;
        fma_res    <= fma_a + fma_b + fma_c;
      end
    end else if (fma_valid) begin
      fma_cnt <= rnd ? int'($urandom_range(5, 1)) : fma_dly;
      fa_s <= fma_a;
      fb_s <= fma_b;
      fc_s <= fma_c;
    end
  end

  always @(posedge clock) if (cmp_valid) cand_q.push_back(lut_addr);

  task automatic start(input logic [31:0] xv);
    int n = 0;
    @(negedge clock);
    while (!in_ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL start_ready: in_ready never rose");
    end
    in_valid = 1'b1;
    in_x = xv;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL wait_out: out_valid never rose");
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [47:0] got;
    @(negedge clock);
    got = {in_ready, out_valid, out_y, out_seg, out_err,
           cmp_valid, fma_valid, lut_addr, busy};
    checks++;
    if (got !== {1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 5'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %h", got);
    end
  endtask

  task automatic test_segment();
    logic [24:0] cands;
    cand_q.delete();
    start(32'hC030_0000);
    wait_out();
    cands = '0;
    foreach (cand_q[i]) if (i < 5) cands[24-5*i -: 5] = cand_q[i];
    checks++;
    if (cand_q.size() != 5 || cands !== {5'd16, 5'd24, 5'd20, 5'd22, 5'd21}) begin
      errors++;
      $display("FAIL seg_cands: got %0d cands %h, want 5 cands %h",
               cand_q.size(), cands, {5'd16, 5'd24, 5'd20, 5'd22, 5'd21});
    end
    checks++;
    if (out_seg !== 5'd21 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL seg_result: seg %0d err %b, want 21 0", out_seg, out_err);
    end
    checks++;
    if ({fa_s, fb_s, fc_s} !== {sl_t[21], 32'hC030_0000, ic_t[21]}) begin
      errors++;
      $display("FAIL seg_fma_ops: got %h %h %h", fa_s, fb_s, fc_s);
    end
    checks++;
    if (out_y !== sl_t[21] + 32'hC030_0000 + ic_t[21]) begin
      errors++;
      $display("FAIL seg_y: got %h want %h", out_y, sl_t[21] + 32'hC030_0000 + ic_t[21]);
    end
    accept();
  endtask

  task automatic test_clamp();
    start(fp_of_q(-36));
    wait_out();
    checks++;
    if (out_seg !== 5'd0 || out_err !== 1'b0 || out_y !== sl_t[0] + 32'hC110_0000 + ic_t[0]) begin
      errors++;
      $display("FAIL clamp_low: seg %0d err %b y %h", out_seg, out_err, out_y);
    end
    accept();
    start(32'h3F80_0000);
    wait_out();
    checks++;
    if (out_seg !== 5'd31 || out_err !== 1'b0 || out_y !== sl_t[31] + 32'h3F80_0000 + ic_t[31]) begin
      errors++;
      $display("FAIL clamp_high: seg %0d err %b y %h", out_seg, out_err, out_y);
    end
    accept();
  endtask

  task automatic test_hold();
    logic [36:0] snap;
    int bad = 0;
    start(fp_of_q(-20));
    wait_out();
    snap = {out_y, out_seg};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (!out_valid || in_ready || {out_y, out_seg} !== snap) bad++;
    end
    checks++;
    if (bad != 0 || snap[4:0] !== 5'd12) begin
      errors++;
      $display("FAIL hold_stable: %0d unstable cycles, seg %0d want 12", bad, snap[4:0]);
    end
    accept();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: in_ready %b out_valid %b busy %b", in_ready, out_valid, busy);
    end
    start(fp_of_q(-31));
    wait_out();
    checks++;
    if (out_seg !== 5'd1) begin
      errors++;
      $display("FAIL hold_next: seg %0d want 1", out_seg);
    end
    accept();
  endtask

  task automatic test_timeout();
    int n = 0;
    cmp_en = 1'b0;
    start(fp_of_q(-11));
    while (!cmp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (!out_valid && n < 1000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n != 255) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d want 255", n);
    end
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_y !== 32'h0 || out_seg !== 5'd0) begin
      errors++;
      $display("FAIL timeout_result: v %b err %b y %h seg %0d", out_valid, out_err, out_y, out_seg);
    end
    cmp_done_f = 1'b1;
    @(negedge clock);
    cmp_done_f = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_y !== 32'h0) begin
      errors++;
      $display("FAIL timeout_late_out: v %b err %b y %h", out_valid, out_err, out_y);
    end
    accept();
    cmp_done_f = 1'b1;
    @(negedge clock);
    cmp_done_f = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || cmp_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_late_idle: rdy %b v %b", in_ready, out_valid);
    end
    cmp_en = 1'b1;
  endtask

  task automatic test_reset_fwait();
    logic [47:0] got;
    int n = 0;
    int seen = 0;
    fma_dly = 6;
    start(fp_of_q(-5));
    while (!fma_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    got = {in_ready, out_valid, out_y, out_seg, out_err,
           cmp_valid, fma_valid, lut_addr, busy};
    checks++;
    if (got !== {1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 5'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_fwait: got %h", got);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (out_valid || !in_ready) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_late_fma: %0d cycles with output activity, want 0", seen);
    end
    fma_dly = 1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] xv;
    int g;
    rnd = 1'b1;
    for (int k = 0; k < 100; k++) begin
      xv = fp_of_q(int'($urandom_range(50, 0)) - 40);
      g = gold(xv);
      start(xv);
      wait_out();
      checks++;
      if (out_seg !== 5'(g) || out_err !== 1'b0 || out_y !== sl_t[g] + xv + ic_t[g]) begin
        errors++;
        $display("FAIL b2b_%0d: x %h seg %0d err %b y %h, want seg %0d y %h",
                 k, xv, out_seg, out_err, out_y, g, sl_t[g] + xv + ic_t[g]);
      end
      accept();
    end
    rnd = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      bp_t[i] = fp_of_q(-32 + i);
      sl_t[i] = 32'h3F80_0000 + 32'(i);
      ic_t[i] = 32'h4000_0000 + 32'(i << 4);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_segment();
    test_clamp();
    test_hold();
    test_timeout();
    test_reset_fwait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
